// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the datapath blocks of the 8-bit teaching CPU.
//   - opcode_e      : instruction opcodes (instr[7:4])
//   - step_t        : micro-step encoding T0..T7
//   - CTL_* / M_*   : control word bit indices and one-hot masks
//   - ctrl_t        : packed control word driven by the microcode ROM
// ----------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'b0000,
        OP_LDA = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0011,
        OP_STA = 4'b0100,
        OP_LDI = 4'b0101,
        OP_JMP = 4'b0110,
        OP_JC  = 4'b0111,
        OP_JZ  = 4'b1000,
        OP_OUT = 4'b1110,
        OP_HLT = 4'b1111
    } opcode_e;

    localparam int STEP_W = 3;
    typedef logic [STEP_W-1:0] step_t;

    localparam step_t STEP_T0 = 3'd0;
    localparam step_t STEP_T1 = 3'd1;
    localparam step_t STEP_T2 = 3'd2;
    localparam step_t STEP_T3 = 3'd3;
    localparam step_t STEP_T4 = 3'd4;

    localparam int NUM_CTL = 15;
    typedef logic [NUM_CTL-1:0] ctrl_t;

    localparam int CTL_COUNTER_OUT    = 0;
    localparam int CTL_COUNTER_ENABLE = 1;
    localparam int CTL_JUMP           = 2;
    localparam int CTL_MAR_IN         = 3;
    localparam int CTL_RAM_IN         = 4;
    localparam int CTL_RAM_OUT        = 5;
    localparam int CTL_IR_IN          = 6;
    localparam int CTL_IR_OUT         = 7;
    localparam int CTL_A_IN           = 8;
    localparam int CTL_A_OUT          = 9;
    localparam int CTL_B_IN           = 10;
    localparam int CTL_ALU_OUT        = 11;
    localparam int CTL_ALU_SUB        = 12;
    localparam int CTL_FLAGS_IN       = 13;
    localparam int CTL_OUT_IN         = 14;

    localparam ctrl_t M_COUNTER_OUT    = ctrl_t'(1) << CTL_COUNTER_OUT;
    localparam ctrl_t M_COUNTER_ENABLE = ctrl_t'(1) << CTL_COUNTER_ENABLE;
    localparam ctrl_t M_JUMP           = ctrl_t'(1) << CTL_JUMP;
    localparam ctrl_t M_MAR_IN         = ctrl_t'(1) << CTL_MAR_IN;
    localparam ctrl_t M_RAM_IN         = ctrl_t'(1) << CTL_RAM_IN;
    localparam ctrl_t M_RAM_OUT        = ctrl_t'(1) << CTL_RAM_OUT;
    localparam ctrl_t M_IR_IN          = ctrl_t'(1) << CTL_IR_IN;
    localparam ctrl_t M_IR_OUT         = ctrl_t'(1) << CTL_IR_OUT;
    localparam ctrl_t M_A_IN           = ctrl_t'(1) << CTL_A_IN;
    localparam ctrl_t M_A_OUT          = ctrl_t'(1) << CTL_A_OUT;
    localparam ctrl_t M_B_IN           = ctrl_t'(1) << CTL_B_IN;
    localparam ctrl_t M_ALU_OUT        = ctrl_t'(1) << CTL_ALU_OUT;
    localparam ctrl_t M_ALU_SUB        = ctrl_t'(1) << CTL_ALU_SUB;
    localparam ctrl_t M_FLAGS_IN       = ctrl_t'(1) << CTL_FLAGS_IN;
    localparam ctrl_t M_OUT_IN         = ctrl_t'(1) << CTL_OUT_IN;

endpackage

// File: rtl/microcode_rom.sv
// ----------------------------------------------------------------------------
// microcode_rom
// Purely combinational decode of (step, opcode, flags, halted) into the
// datapath control word.
//   step        in   current micro-step
//   opcode      in   instr[7:4]
//   carry_flag  in   carry flag, only consulted by JC in T2
//   zero_flag   in   zero flag, only consulted by JZ in T2
//   halted      in   machine halted; forces an all-zero control word
//   ctrl        out  control word, bit positions given by cpu_pkg::CTL_*
// ----------------------------------------------------------------------------
module microcode_rom
    import cpu_pkg::*;
#(
    parameter logic [3:0] HLT_OPCODE = 4'b1111
) (
    input  step_t      step,
    input  logic [3:0] opcode,
    input  logic       carry_flag,
    input  logic       zero_flag,
    input  logic       halted,
    output ctrl_t      ctrl
);

    // Fetch (T0/T1) is shared by every opcode; execute steps decode the
    // opcode. The halt opcode produces nothing in T2 even if it aliases a
    // defined opcode, and steps past T4 are always idle.
    always_comb begin
        ctrl = '0;
        if (!halted) begin
            case (step)
                STEP_T0: ctrl = M_COUNTER_OUT | M_MAR_IN;
                STEP_T1: ctrl = M_RAM_OUT | M_IR_IN | M_COUNTER_ENABLE;
                STEP_T2: begin
                    if (opcode != HLT_OPCODE) begin
                        case (opcode_e'(opcode))
                            OP_LDA, OP_ADD, OP_SUB, OP_STA:
                                ctrl = M_IR_OUT | M_MAR_IN;
                            OP_LDI:  ctrl = M_IR_OUT | M_A_IN;
                            OP_JMP:  ctrl = M_IR_OUT | M_JUMP;
                            OP_JC:   ctrl = carry_flag ? (M_IR_OUT | M_JUMP) : '0;
                            OP_JZ:   ctrl = zero_flag ? (M_IR_OUT | M_JUMP) : '0;
                            OP_OUT:  ctrl = M_A_OUT | M_OUT_IN;
                            default: ctrl = '0;
                        endcase
                    end
                end
                STEP_T3: begin
                    case (opcode_e'(opcode))
                        OP_LDA:         ctrl = M_RAM_OUT | M_A_IN;
                        OP_ADD, OP_SUB: ctrl = M_RAM_OUT | M_B_IN;
                        OP_STA:         ctrl = M_A_OUT | M_RAM_IN;
                        default:        ctrl = '0;
                    endcase
                end
                STEP_T4: begin
                    case (opcode_e'(opcode))
                        OP_ADD:  ctrl = M_ALU_OUT | M_A_IN | M_FLAGS_IN;
                        OP_SUB:  ctrl = M_ALU_OUT | M_ALU_SUB | M_A_IN | M_FLAGS_IN;
                        default: ctrl = '0;
                    endcase
                end
                default: ctrl = '0;
            endcase
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// ----------------------------------------------------------------------------
// control_sequencer
// Micro-step counter and halt latch for the teaching CPU; decode of the
// control word is delegated to microcode_rom.
//   clk                 in   rising-edge clock
//   clear_n             in   asynchronous active-low reset
//   instr[7:0]          in   instruction register, opcode = instr[7:4]
//   carry_flag          in   flags register carry
//   zero_flag           in   flags register zero
//   step[2:0]           out  current micro-step
//   halted              out  sticky halt indicator
//   counter_out, counter_enable, jump                     out  PC controls
//   mar_in, ram_in, ram_out, ir_in, ir_out, a_in, a_out,
//   b_in, alu_out, alu_sub, flags_in, out_in              out  datapath controls
// ----------------------------------------------------------------------------
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int         NUM_STEPS  = 5,
    parameter logic [3:0] HLT_OPCODE = 4'b1111
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic [7:0] instr,
    input  logic       carry_flag,
    input  logic       zero_flag,
    output logic [2:0] step,
    output logic       halted,
    output logic       counter_out,
    output logic       counter_enable,
    output logic       jump,
    output logic       mar_in,
    output logic       ram_in,
    output logic       ram_out,
    output logic       ir_in,
    output logic       ir_out,
    output logic       a_in,
    output logic       a_out,
    output logic       b_in,
    output logic       alu_out,
    output logic       alu_sub,
    output logic       flags_in,
    output logic       out_in
);

    localparam step_t LAST_STEP = step_t'(NUM_STEPS - 1);

    step_t      step_q, step_d;
    logic       halted_q, halted_d;
    logic [3:0] opcode;
    ctrl_t      ctrl;
    logic       unused_operand;

    assign opcode         = instr[7:4];
    assign unused_operand = ^instr[3:0];

    // Next-state: the step counter wraps at the last step. Seeing the halt
    // opcode in T2 latches halted and parks the counter at T2; once halted
    // nothing moves until reset.
    always_comb begin
        step_d   = step_q;
        halted_d = halted_q;
        if (!halted_q) begin
            if (step_q == STEP_T2 && opcode == HLT_OPCODE) begin
                halted_d = 1'b1;
            end else if (step_q == LAST_STEP) begin
                step_d = STEP_T0;
            end else begin
                step_d = step_q + 3'd1;
            end
        end
    end

    // State registers; reset drops straight back to T0 and clears halt.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            step_q   <= STEP_T0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    microcode_rom #(
        .HLT_OPCODE (HLT_OPCODE)
    ) u_rom (
        .step       (step_q),
        .opcode     (opcode),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .halted     (halted_q),
        .ctrl       (ctrl)
    );

    assign step           = step_q;
    assign halted         = halted_q;
    assign counter_out    = ctrl[CTL_COUNTER_OUT];
    assign counter_enable = ctrl[CTL_COUNTER_ENABLE];
    assign jump           = ctrl[CTL_JUMP];
    assign mar_in         = ctrl[CTL_MAR_IN];
    assign ram_in         = ctrl[CTL_RAM_IN];
    assign ram_out        = ctrl[CTL_RAM_OUT];
    assign ir_in          = ctrl[CTL_IR_IN];
    assign ir_out         = ctrl[CTL_IR_OUT];
    assign a_in           = ctrl[CTL_A_IN];
    assign a_out          = ctrl[CTL_A_OUT];
    assign b_in           = ctrl[CTL_B_IN];
    assign alu_out        = ctrl[CTL_ALU_OUT];
    assign alu_sub        = ctrl[CTL_ALU_SUB];
    assign flags_in       = ctrl[CTL_FLAGS_IN];
    assign out_in         = ctrl[CTL_OUT_IN];

endmodule

// File: tb/tb_control_sequencer.sv
// ----------------------------------------------------------------------------
// tb_control_sequencer
// Directed and randomized checks of control_sequencer against a table-driven
// reference of the microprogram kept in this bench.
// ----------------------------------------------------------------------------
module tb_control_sequencer;

    localparam int NUM_STEPS = 5;

    // Bench-local control word layout, MSB first, matching ctrlObs below.
    localparam logic [14:0] CO = 15'h4000;
    localparam logic [14:0] CE = 15'h2000;
    localparam logic [14:0] J  = 15'h1000;
    localparam logic [14:0] MI = 15'h0800;
    localparam logic [14:0] RI = 15'h0400;
    localparam logic [14:0] RO = 15'h0200;
    localparam logic [14:0] II = 15'h0100;
    localparam logic [14:0] IO = 15'h0080;
    localparam logic [14:0] AI = 15'h0040;
    localparam logic [14:0] AO = 15'h0020;
    localparam logic [14:0] BI = 15'h0010;
    localparam logic [14:0] EO = 15'h0008;
    localparam logic [14:0] SU = 15'h0004;
    localparam logic [14:0] FI = 15'h0002;
    localparam logic [14:0] OI = 15'h0001;
    localparam logic [14:0] BUS_DRIVERS = CO | RO | IO | AO | EO;

    logic       clk = 1'b0;
    logic       clear_n;
    logic [7:0] instr;
    logic       carry_flag;
    logic       zero_flag;
    logic [2:0] step;
    logic       halted;
    logic       counter_out, counter_enable, jump;
    logic       mar_in, ram_in, ram_out, ir_in, ir_out;
    logic       a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in;
    logic [14:0] ctrlObs;

    int nChecks = 0;
    int nFails  = 0;

    int expStep;
    bit expHalted;
    logic [14:0] micro [16][8];

    always #5 clk = ~clk;

    assign ctrlObs = {counter_out, counter_enable, jump, mar_in, ram_in, ram_out,
                      ir_in, ir_out, a_in, a_out, b_in, alu_out, alu_sub,
                      flags_in, out_in};

    control_sequencer #(
        .NUM_STEPS  (NUM_STEPS),
        .HLT_OPCODE (4'b1111)
    ) dut (
        .clk            (clk),
        .clear_n        (clear_n),
        .instr          (instr),
        .carry_flag     (carry_flag),
        .zero_flag      (zero_flag),
        .step           (step),
        .halted         (halted),
        .counter_out    (counter_out),
        .counter_enable (counter_enable),
        .jump           (jump),
        .mar_in         (mar_in),
        .ram_in         (ram_in),
        .ram_out        (ram_out),
        .ir_in          (ir_in),
        .ir_out         (ir_out),
        .a_in           (a_in),
        .a_out          (a_out),
        .b_in           (b_in),
        .alu_out        (alu_out),
        .alu_sub        (alu_sub),
        .flags_in       (flags_in),
        .out_in         (out_in)
    );

    // The microprogram written out as a table of control sets, one row per
    // opcode and column per step; anything not listed stays empty.
    task automatic buildMicroprogram();
        for (int op = 0; op < 16; op++) begin
            for (int s = 0; s < 8; s++) micro[op][s] = '0;
            micro[op][0] = CO | MI;
            micro[op][1] = RO | II | CE;
        end
        micro[1][2]  = IO | MI;  micro[1][3] = RO | AI;
        micro[2][2]  = IO | MI;  micro[2][3] = RO | BI;  micro[2][4] = EO | AI | FI;
        micro[3][2]  = IO | MI;  micro[3][3] = RO | BI;  micro[3][4] = EO | AI | FI | SU;
        micro[4][2]  = IO | MI;  micro[4][3] = AO | RI;
        micro[5][2]  = IO | AI;
        micro[6][2]  = IO | J;
        micro[7][2]  = IO | J;
        micro[8][2]  = IO | J;
        micro[14][2] = AO | OI;
    endtask

    // Expected controls for the current model state and live inputs;
    // conditional jumps only fire in T2 with their flag set.
    function automatic logic [14:0] expCtrl();
        logic [3:0]  op;
        logic [14:0] v;
        op = instr[7:4];
        if (expHalted) return '0;
        v = micro[op][expStep];
        if (expStep == 2 && op == 4'h7 && !carry_flag) v = '0;
        if (expStep == 2 && op == 4'h8 && !zero_flag)  v = '0;
        return v;
    endfunction

    task automatic applyStimulus(input logic [7:0] i, input logic c, input logic z);
        instr      = i;
        carry_flag = c;
        zero_flag  = z;
        #1;
    endtask

    // One rising edge: advance the model with the inputs present at the edge,
    // then step off the edge before anything is sampled.
    task automatic clockCycle();
        @(posedge clk);
        if (clear_n && !expHalted) begin
            if (expStep == 2 && instr[7:4] == 4'hF) expHalted = 1'b1;
            else expStep = (expStep + 1) % NUM_STEPS;
        end
        #1;
    endtask

    task automatic doReset();
        clear_n   = 1'b0;
        expStep   = 0;
        expHalted = 1'b0;
        #1;
    endtask

    task automatic releaseReset();
        clear_n = 1'b1;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $display("[TB] FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
            $error("[TB] assertion on %s", tag);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "_step"}, 32'(step), 32'(expStep));
        checkOutput({tag, "_halted"}, 32'(halted), 32'(expHalted));
        checkOutput({tag, "_ctrl"}, 32'(ctrlObs), 32'(expCtrl()));
    endtask

    task automatic checkBus(input string tag);
        checkOutput(tag, 32'($countones(ctrlObs & BUS_DRIVERS) <= 1), 32'd1);
    endtask

    initial begin
        logic [7:0] r;
        int haltCycles;
        buildMicroprogram();

        // Reset state shows the T0 decode
        clear_n = 1'b0;
        expStep = 0;
        expHalted = 1'b0;
        applyStimulus(8'h2E, 1'b0, 1'b0);
        checkAll("reset");
        checkOutput("reset_ctrl", 32'(ctrlObs), 32'(CO | MI));
        clockCycle();
        checkAll("reset_held");

        // First edge after release goes to T1
        releaseReset();
        clockCycle();
        checkOutput("first_edge_step", 32'(step), 32'd1);

        // ADD walk back round to T0, then a full instruction
        for (int k = 0; k < 4; k++) begin
            clockCycle();
            checkAll("add_wrap");
        end
        checkOutput("add_at_t0", 32'(step), 32'd0);
        clockCycle();
        clockCycle();
        clockCycle();
        checkOutput("add_t3_ctrl", 32'(ctrlObs), 32'(RO | BI));
        clockCycle();
        checkOutput("add_t4_ctrl", 32'(ctrlObs), 32'(EO | AI | FI));
        checkOutput("add_t4_sub", 32'(alu_sub), 32'd0);
        clockCycle();
        checkOutput("add_wrap_step", 32'(step), 32'd0);

        // Asynchronous reset in the middle of ADD T3
        clockCycle();
        clockCycle();
        clockCycle();
        checkOutput("pre_reset_t3", 32'(step), 32'd3);
        doReset();
        checkOutput("midt3_step", 32'(step), 32'd0);
        checkOutput("midt3_ctrl", 32'(ctrlObs), 32'(CO | MI));
        checkOutput("midt3_alu_out", 32'(alu_out), 32'd0);
        releaseReset();

        // JC with carry clear then set
        applyStimulus(8'h75, 1'b0, 1'b0);
        clockCycle();
        clockCycle();
        checkOutput("jc_c0_ctrl", 32'(ctrlObs), 32'd0);
        applyStimulus(8'h75, 1'b1, 1'b0);
        checkOutput("jc_c1_ctrl", 32'(ctrlObs), 32'(IO | J));
        checkAll("jc_c1");
        clockCycle();
        checkOutput("jc_c1_t3_jump", 32'(jump), 32'd0);
        checkOutput("jc_c1_t3_irout", 32'(ir_out), 32'd0);
        clockCycle();
        clockCycle();

        // JZ with the zero flag raised only during T3
        for (int s = 0; s < NUM_STEPS; s++) begin
            applyStimulus(8'h80, 1'b0, (s == 3));
            checkOutput("jz_jump", 32'(jump), 32'd0);
            checkAll("jz");
            clockCycle();
        end

        // Every opcode through every step; bus exclusivity and decode
        for (int op = 0; op < 16; op++) begin
            doReset();
            releaseReset();
            for (int s = 0; s < NUM_STEPS; s++) begin
                r = 8'($urandom);
                applyStimulus({4'(op), r[3:0]}, r[4], r[5]);
                checkBus("sweep_bus");
                checkAll("sweep");
                clockCycle();
            end
        end

        // Random instruction stream against the model
        doReset();
        releaseReset();
        haltCycles = 0;
        for (int k = 0; k < 400; k++) begin
            if (expHalted) haltCycles++;
            if (haltCycles > 3) begin
                doReset();
                releaseReset();
                haltCycles = 0;
            end
            r = 8'($urandom);
            if (r[7:4] == 4'hF && $urandom_range(0, 3) != 0) r[7:4] = 4'h2;
            applyStimulus(r, 1'($urandom), 1'($urandom));
            checkBus("rand_bus");
            checkAll("rand");
            clockCycle();
        end

        // HLT: latch at the T2 edge, freeze, then recover through reset
        doReset();
        releaseReset();
        applyStimulus(8'hF0, 1'b0, 1'b0);
        checkAll("hlt_t0");
        clockCycle();
        clockCycle();
        checkOutput("hlt_t2_ctrl", 32'(ctrlObs), 32'd0);
        checkOutput("hlt_t2_halted", 32'(halted), 32'd0);
        clockCycle();
        checkOutput("hlt_latched", 32'(halted), 32'd1);
        for (int k = 0; k < 10; k++) begin
            r = 8'($urandom);
            applyStimulus(r, r[0], r[1]);
            clockCycle();
            checkOutput("hlt_freeze_step", 32'(step), 32'd2);
            checkOutput("hlt_freeze_ctrl", 32'(ctrlObs), 32'd0);
            checkOutput("hlt_freeze_halted", 32'(halted), 32'd1);
        end
        doReset();
        checkOutput("hlt_clear_halted", 32'(halted), 32'd0);
        checkOutput("hlt_clear_step", 32'(step), 32'd0);
        checkOutput("hlt_clear_ctrl", 32'(ctrlObs), 32'(CO | MI));
        releaseReset();
        clockCycle();
        checkOutput("hlt_restart_step", 32'(step), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter NUM_STEPS, default 5, SHALL set the micro-steps per instruction (legal 5..8).
REQ-002 Parameter HLT_OPCODE, default 4'b1111, SHALL set the opcode that halts the machine.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 clear_n  input  1  reset, asynchronous, active-low.
REQ-005 instr  input  8  instruction register contents; opcode = instr[7:4].
REQ-006 carry_flag, zero_flag  input  1 each  flags register outputs.
REQ-007 step  output  3  current micro-step T0..T(NUM_STEPS-1).
REQ-008 halted  output  1  sticky halt indicator.
REQ-009 counter_out, counter_enable, jump  output  1 each  program counter controls.
REQ-010 mar_in, ram_in, ram_out, ir_in, ir_out, a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in  output  1 each  bus/load controls for the remaining datapath stages.

Function
REQ-011 step SHALL increment by 1 per clock and wrap from NUM_STEPS-1 to 0.
REQ-012 Control outputs SHALL be combinational from (step, opcode, carry_flag, zero_flag, halted), with no registered latency; unlisted controls SHALL be 0.
REQ-013 T0: counter_out, mar_in. T1: ram_out, ir_in, counter_enable. These SHALL apply to every opcode.
REQ-014 LDA 0001: T2 ir_out, mar_in; T3 ram_out, a_in.
REQ-015 ADD 0010: T2 ir_out, mar_in; T3 ram_out, b_in; T4 alu_out, a_in, flags_in.
REQ-016 SUB 0011: same as ADD, with alu_sub also asserted in T4.
REQ-017 STA 0100: T2 ir_out, mar_in; T3 a_out, ram_in.
REQ-018 LDI 0101: T2 ir_out, a_in.
REQ-019 JMP 0110: T2 ir_out, jump.
REQ-020 JC 0111: T2 ir_out, jump only when carry_flag=1; otherwise no controls.
REQ-021 JZ 1000: T2 ir_out, jump only when zero_flag=1; otherwise no controls.
REQ-022 OUT 1110: T2 a_out, out_in.
REQ-023 NOP 0000 and undefined opcodes SHALL assert no controls in T2..T(NUM_STEPS-1).
REQ-024 At most one bus driver (counter_out, ram_out, ir_out, a_out, alu_out) SHALL be asserted in any step.
REQ-025 HLT_OPCODE in T2 SHALL set halted at that clock edge; thereafter step SHALL freeze at 2 and all controls SHALL be 0 until reset.
REQ-026 Steps beyond T4 when NUM_STEPS>5 SHALL assert no controls.
REQ-027 Flag inputs SHALL be sampled combinationally in T2 only; flag changes in other steps SHALL have no effect.

Reset
REQ-028 clear_n=0 SHALL immediately force step=0 and halted=0, independent of clk, including mid-instruction and while halted.
REQ-029 While in reset, outputs SHALL equal the T0 decode (counter_out=1, mar_in=1, all other controls 0).
REQ-030 The first rising clk edge after clear_n rises SHALL advance step to 1.

Structure
REQ-031 Opcode constants, step encodings and control-bit indices SHALL reside in a shared package, cpu_pkg, used by all datapath blocks.
REQ-032 The opcode/step-to-control decode SHALL be one combinational sub-module, microcode_rom; step and halt registers SHALL stay in control_sequencer.

Verification
REQ-033 Reset mid-T3 of ADD (instr=8'h2E) -> step=0 asynchronously, counter_out=1, mar_in=1, alu_out=0.
REQ-034 instr=8'h2E, clock 5 cycles from T0 -> T3 ram_out+b_in; T4 alu_out+a_in+flags_in, alu_sub=0; then step wraps to 0.
REQ-035 instr=8'h75, carry_flag=0 at T2 -> jump=0, ir_out=0; repeat with carry_flag=1 -> jump=1, ir_out=1 in T2 only.
REQ-036 instr=8'h80 with zero_flag toggled 1 in T3 only -> jump never asserted.
REQ-037 instr=8'hF0 -> halted=1 after T2 edge, step stays 2 for 10 clocks, all controls 0; clear_n pulse -> halted=0, step=0.
REQ-038 Sweep all 16 opcodes and all 5 steps -> bus-driver count never exceeds 1.
